// File: rtl/comp_serial.sv
// Sequential MSB-first magnitude comparator: scans DIGIT bits per clock and
// stops at the first differing digit. Valid/ready handshakes on both sides.
module comp_serial #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGIT  = 2,
    parameter bit          SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Zx,
    output logic             Zy,
    output logic             Zeq,
    output logic             busy
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] MSB_FLIP =
        SIGNED ? ({{(WIDTH-1){1'b0}}, 1'b1} << (WIDTH - 1)) : {WIDTH{1'b0}};

    generate
        if ((DIGIT == 0) || (WIDTH % DIGIT != 0) || (WIDTH < 2)) begin : g_bad_digit
            $error("comp_serial: DIGIT must be non-zero and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sx_q, sx_d;
    logic [WIDTH-1:0] sy_q, sy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             zx_q, zx_d;
    logic             zy_q, zy_d;
    logic             zeq_q, zeq_d;
    logic [DIGIT-1:0] dx_s, dy_s;

    assign dx_s      = sx_q[WIDTH-1 -: DIGIT];
    assign dy_s      = sy_q[WIDTH-1 -: DIGIT];
    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign Zx        = zx_q;
    assign Zy        = zy_q;
    assign Zeq       = zeq_q;

    // Next-state and datapath logic for the scan FSM.
    always_comb begin
        state_d     = state_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        zx_d        = zx_q;
        zy_d        = zy_q;
        zeq_d       = zeq_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sx_d    = X ^ MSB_FLIP;
                    sy_d    = Y ^ MSB_FLIP;
                    cnt_d   = CNT_LAST;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (dx_s > dy_s) begin
                    zx_d        = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (dx_s < dy_s) begin
                    zy_d        = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (cnt_q == {CW{1'b0}}) begin
                    zeq_d       = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    sx_d  = sx_q << DIGIT;
                    sy_d  = sy_q << DIGIT;
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    zx_d        = 1'b0;
                    zy_d        = 1'b0;
                    zeq_d       = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                zx_d        = 1'b0;
                zy_d        = 1'b0;
                zeq_d       = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and result registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sx_q        <= {WIDTH{1'b0}};
            sy_q        <= {WIDTH{1'b0}};
            cnt_q       <= {CW{1'b0}};
            out_valid_q <= 1'b0;
            zx_q        <= 1'b0;
            zy_q        <= 1'b0;
            zeq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            zx_q        <= zx_d;
            zy_q        <= zy_d;
            zeq_q       <= zeq_d;
        end
    end

endmodule

// File: tb/tb_comp_serial.sv
// Scoreboard bench for comp_serial: three instances (unsigned DIGIT=2,
// signed DIGIT=2, unsigned DIGIT=8) driven one at a time by directed vectors.
module tb_comp_serial;

    localparam logic [2:0] F_X  = 3'b100;
    localparam logic [2:0] F_Y  = 3'b010;
    localparam logic [2:0] F_EQ = 3'b001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in_valid, in_ready, out_valid, zx, zy, zeq, busy;
    logic       out_ready;
    logic [7:0] x, y;

    typedef struct {
        int         d;
        logic [2:0] flags;
        int         lat;
        int         acc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       me;
    logic [2:0] mf;
    logic [2:0] held [3];
    logic [2:0] prev_ov = 3'b000;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            comp_serial #(
                .WIDTH (8),
                .DIGIT ((g == 2) ? 8 : 2),
                .SIGNED((g == 1) ? 1'b1 : 1'b0)
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_valid (in_valid[g]),
                .in_ready (in_ready[g]),
                .X        (x),
                .Y        (y),
                .out_valid(out_valid[g]),
                .out_ready(out_ready),
                .Zx       (zx[g]),
                .Zy       (zy[g]),
                .Zeq      (zeq[g]),
                .busy     (busy[g])
            );
        end
    endgenerate

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Scoreboard monitor: pops on each rising out_valid, checks hold and idle flags.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                mf = {zx[i], zy[i], zeq[i]};
                if (out_valid[i] && !prev_ov[i]) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        me = exp_q.pop_front();
                        chk("dut_id", i, me.d);
                        chk("flags", int'(mf), int'(me.flags));
                        chk("latency", cyc - me.acc, me.lat);
                        chk("in_ready_in_done", int'(in_ready[i]), 0);
                    end
                    held[i] = mf;
                end else if (out_valid[i]) begin
                    chk("flags_stable", int'(mf), int'(held[i]));
                end else begin
                    chk("flags_idle", int'(mf), 0);
                end
                prev_ov[i] = out_valid[i];
            end
        end
    end

    task automatic wait_ready(input int d, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(in_ready[d]), 1);
    endtask

    task automatic issue(input int d, input logic [7:0] xa, input logic [7:0] ya,
                         input logic [2:0] f, input int lat, input bit track);
        wait_ready(d, "ready_before_issue");
        in_valid[d] = 1'b1;
        x = xa;
        y = ya;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        if (track) exp_q.push_back('{d, f, lat, cyc});
        chk("ready_after_accept", int'(in_ready[d]), 0);
        chk("busy_after_accept", int'(busy[d]), 1);
        x = ~xa;
        y = ~ya;
    endtask

    task automatic run(input int d, input logic [7:0] xa, input logic [7:0] ya,
                       input logic [2:0] f, input int lat);
        issue(d, xa, ya, f, lat, 1'b1);
        wait_ready(d, "return_to_idle");
    endtask

    task automatic reset_midop(input int d, input int lat);
        issue(d, 8'hA5, 8'hA5, F_EQ, lat, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("ready_after_reset", int'(in_ready[d]), 1);
        chk("valid_after_reset", int'(out_valid[d]), 0);
        repeat (6) @(negedge clk);
        run(d, 8'h03, 8'h02, F_X, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 3'b000;
        out_ready = 1'b1;
        x         = 8'h00;
        y         = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_in_ready", int'(in_ready), 7);
        chk("reset_busy", int'(busy), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_flags", int'({zx, zy, zeq}), 0);
        mon_en = 1'b1;

        // Unsigned, 2-bit digits: latency equals index of first differing digit.
        run(0, 8'hA5, 8'hA5, F_EQ, 4);
        run(0, 8'h80, 8'h7F, F_X, 1);
        run(0, 8'h12, 8'h13, F_Y, 4);
        run(0, 8'h13, 8'h12, F_X, 4);
        run(0, 8'h00, 8'hFF, F_Y, 1);
        run(0, 8'h00, 8'h00, F_EQ, 4);
        run(0, 8'h34, 8'h24, F_X, 2);
        run(0, 8'h38, 8'h3C, F_Y, 3);

        // Signed compare.
        run(1, 8'h80, 8'h01, F_Y, 1);
        run(1, 8'hFF, 8'hFE, F_X, 4);
        run(1, 8'h7F, 8'h80, F_X, 1);
        run(1, 8'hFF, 8'h01, F_Y, 1);
        run(1, 8'h80, 8'h80, F_EQ, 4);

        // Backpressure, with a stray in_valid while busy.
        out_ready = 1'b0;
        issue(0, 8'hC0, 8'h40, F_X, 1, 1'b1);
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid[0]), 1);
            chk("bp_zx", int'(zx[0]), 1);
            chk("bp_in_ready", int'(in_ready[0]), 0);
            if (i == 2) begin
                in_valid[0] = 1'b1;
                x = 8'h01;
                y = 8'hF0;
            end else begin
                in_valid[0] = 1'b0;
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_handshake", int'(in_ready[0]), 1);
        chk("valid_after_handshake", int'(out_valid[0]), 0);

        // Stray in_valid during RUN is ignored.
        issue(0, 8'h12, 8'h13, F_Y, 4, 1'b1);
        in_valid[0] = 1'b1;
        x = 8'hFF;
        y = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        wait_ready(0, "return_to_idle");

        reset_midop(0, 4);

        // Single-cycle scan.
        run(2, 8'hA5, 8'hA5, F_EQ, 1);
        run(2, 8'h80, 8'h7F, F_X, 1);
        run(2, 8'h12, 8'h13, F_Y, 1);
        run(2, 8'h13, 8'h12, F_X, 1);
        reset_midop(2, 1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
